// File: rtl/priority_encoder_148_pkg.sv
// Shared types and helpers for the registered 8-to-3 priority encoder.
// Holds the debounce state encoding, counter width and the priority function.
package prio_enc_pkg;

  localparam int PE_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } pe_state_t;

  // Binary index of the highest-numbered low bit; 0 when no bit is low.
  function automatic logic [2:0] prio8(input logic [7:0] act_n);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!act_n[i]) idx = i[2:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/priority_encoder_148_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Resets to a caller-chosen idle pattern so nothing looks active after reset.
module sync_2ff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta_p0;
  logic [W-1:0] r_sync_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta_p0 <= RST_VAL;
      r_sync_p1 <= RST_VAL;
    end else begin
      r_meta_p0 <= i_d;
      r_sync_p1 <= r_meta_p0;
    end
  end

  assign o_q = r_sync_p1;

endmodule

// File: rtl/priority_encoder_148.sv
// Registered 74148-style active-low priority encoder with cascade pins,
// plus a debounced key-event channel emitting one pulse per stable press.
module priority_encoder_148
  import prio_enc_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ei_n,
  input  logic [7:0] key_n,
  output logic [2:0] a_n,
  output logic       gs_n,
  output logic       eo_n,
  output logic       key_valid,
  output logic [2:0] key_code
);

  localparam logic [PE_CNT_W-1:0] LP_DEB = PE_CNT_W'(DEBOUNCE);

  function automatic logic [PE_CNT_W-1:0] sat_inc(input logic [PE_CNT_W-1:0] v);
    return (v >= LP_DEB) ? v : v + 1'b1;
  endfunction

  logic [8:0] w_sync_p1;
  logic       w_es;
  logic [7:0] w_ks;
  logic       w_active;
  logic [2:0] w_code;

  sync_2ff #(
    .W       (9),
    .RST_VAL (9'h1FF)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d ({ei_n, key_n}),
    .o_q (w_sync_p1)
  );

  assign w_es     = w_sync_p1[8];
  assign w_ks     = w_sync_p1[7:0];
  assign w_active = !w_es && (w_ks != 8'hFF);
  assign w_code   = prio8(w_ks);

  // Stage p2: registered encoder outputs
  logic [2:0] r_a_n_p2;
  logic       r_gs_n_p2;
  logic       r_eo_n_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_n_p2  <= 3'b111;
      r_gs_n_p2 <= 1'b1;
      r_eo_n_p2 <= 1'b1;
    end else if (w_es) begin
      r_a_n_p2  <= 3'b111;
      r_gs_n_p2 <= 1'b1;
      r_eo_n_p2 <= 1'b1;
    end else if (w_ks == 8'hFF) begin
      r_a_n_p2  <= 3'b111;
      r_gs_n_p2 <= 1'b1;
      r_eo_n_p2 <= 1'b0;
    end else begin
      r_a_n_p2  <= ~w_code;
      r_gs_n_p2 <= 1'b0;
      r_eo_n_p2 <= 1'b1;
    end
  end

  // Stage p2: debounce FSM state and event registers
  pe_state_t             r_state;
  logic [2:0]            r_cand;
  logic [PE_CNT_W-1:0]   r_cnt;
  logic [2:0]            r_key_code;
  logic                  r_key_valid;

  pe_state_t             w_state_nxt;
  logic [2:0]            w_cand_nxt;
  logic [PE_CNT_W-1:0]   w_cnt_nxt;
  logic [2:0]            w_key_code_nxt;
  logic                  w_key_valid_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cand      <= 3'd0;
      r_cnt       <= '0;
      r_key_code  <= 3'd0;
      r_key_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cand      <= w_cand_nxt;
      r_cnt       <= w_cnt_nxt;
      r_key_code  <= w_key_code_nxt;
      r_key_valid <= w_key_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cand_nxt      = r_cand;
    w_cnt_nxt       = r_cnt;
    w_key_code_nxt  = r_key_code;
    w_key_valid_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_active) begin
          w_cand_nxt = w_code;
          w_cnt_nxt  = PE_CNT_W'(1);
          if (DEBOUNCE == 1) begin
            w_key_code_nxt  = w_code;
            w_key_valid_nxt = 1'b1;
            w_state_nxt     = HELD;
          end else begin
            w_state_nxt = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (!w_active) begin
          w_state_nxt = IDLE;
        end else if (w_code != r_cand) begin
          w_cand_nxt = w_code;
          w_cnt_nxt  = PE_CNT_W'(1);
        end else begin
          w_cnt_nxt = sat_inc(r_cnt);
          if (w_cnt_nxt == LP_DEB) begin
            w_key_code_nxt  = r_cand;
            w_key_valid_nxt = 1'b1;
            w_state_nxt     = HELD;
          end
        end
      end
      HELD: begin
        if (!w_active) begin
          w_cnt_nxt   = PE_CNT_W'(1);
          w_state_nxt = RELEASE;
        end else if (w_code != r_key_code) begin
          w_cand_nxt  = w_code;
          w_cnt_nxt   = PE_CNT_W'(1);
          w_state_nxt = SETTLE;
        end
      end
      RELEASE: begin
        if (!w_active) begin
          w_cnt_nxt = sat_inc(r_cnt);
          if (w_cnt_nxt == LP_DEB) w_state_nxt = IDLE;
        end else if (w_code == r_key_code) begin
          // Short release glitch: resume the held key without a new event
          w_state_nxt = HELD;
        end else begin
          w_cand_nxt  = w_code;
          w_cnt_nxt   = PE_CNT_W'(1);
          w_state_nxt = SETTLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign a_n       = r_a_n_p2;
  assign gs_n      = r_gs_n_p2;
  assign eo_n      = r_eo_n_p2;
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;

endmodule

// File: tb/tb_priority_encoder_148.sv
// Directed bench for priority_encoder_148: encoder outputs, latency and
// debounced key events with hand-computed expectations.
module tb_priority_encoder_148;

  logic       clk = 1'b0;
  logic       rst;
  logic       ei_n;
  logic [7:0] key_n;
  logic [2:0] a_n;
  logic       gs_n;
  logic       eo_n;
  logic       key_valid;
  logic [2:0] key_code;

  int checks   = 0;
  int failures = 0;
  int pulse_cnt = 0;
  int p0;

  always #5 clk = ~clk;

  priority_encoder_148 #(.DEBOUNCE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ei_n      (ei_n),
    .key_n     (key_n),
    .a_n       (a_n),
    .gs_n      (gs_n),
    .eo_n      (eo_n),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  always @(negedge clk) begin
    if (key_valid) pulse_cnt++;
  end

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    key_n = 8'hFF;
    ei_n  = 1'b0;
    step(12);
  endtask

  task automatic test_reset();
    rst = 1'b1; ei_n = 1'b0; key_n = 8'h00;
    step(3);
    checks++; if (a_n !== 3'b111) begin failures++; $display("FAIL rst_a_n got=%b exp=111", a_n); end
    checks++; if (gs_n !== 1'b1) begin failures++; $display("FAIL rst_gs_n got=%b exp=1", gs_n); end
    checks++; if (eo_n !== 1'b1) begin failures++; $display("FAIL rst_eo_n got=%b exp=1", eo_n); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL rst_key_valid got=%b exp=0", key_valid); end
    checks++; if (key_code !== 3'd0) begin failures++; $display("FAIL rst_key_code got=%0d exp=0", key_code); end
    rst = 1'b0;
    step(2);
    checks++; if (a_n !== 3'b111) begin failures++; $display("FAIL rst_lat2_a_n got=%b exp=111", a_n); end
    step(1);
    checks++; if (a_n !== 3'b000) begin failures++; $display("FAIL rst_lat3_a_n got=%b exp=000", a_n); end
    checks++; if (gs_n !== 1'b0) begin failures++; $display("FAIL rst_lat3_gs_n got=%b exp=0", gs_n); end
    go_idle();
  endtask

  task automatic test_encode_key2();
    key_n = 8'hFF;
    step(3);
    checks++; if (eo_n !== 1'b0) begin failures++; $display("FAIL idle_eo_n got=%b exp=0", eo_n); end
    checks++; if ({a_n, gs_n} !== 4'b1111) begin failures++; $display("FAIL idle_a_gs got=%b exp=1111", {a_n, gs_n}); end
    p0 = pulse_cnt;
    key_n = 8'hFB;
    step(3);
    checks++; if ({a_n, gs_n, eo_n} !== 5'b10101) begin failures++; $display("FAIL key2_enc got=%b exp=10101", {a_n, gs_n, eo_n}); end
    step(2);
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL key2_early_valid got=%b exp=0", key_valid); end
    step(1);
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL key2_valid got=%b exp=1", key_valid); end
    checks++; if (key_code !== 3'd2) begin failures++; $display("FAIL key2_code got=%0d exp=2", key_code); end
    step(1);
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL key2_one_cycle got=%b exp=0", key_valid); end
    step(4);
    checks++; if (pulse_cnt - p0 !== 1) begin failures++; $display("FAIL key2_pulses got=%0d exp=1", pulse_cnt - p0); end
  endtask

  task automatic test_multi_key();
    p0 = pulse_cnt;
    key_n = 8'h7F;
    step(8);
    checks++; if (a_n !== 3'b000) begin failures++; $display("FAIL key7_a_n got=%b exp=000", a_n); end
    checks++; if (key_code !== 3'd7) begin failures++; $display("FAIL key7_code got=%0d exp=7", key_code); end
    checks++; if (pulse_cnt - p0 !== 1) begin failures++; $display("FAIL key7_pulses got=%0d exp=1", pulse_cnt - p0); end
    key_n = 8'h3F;
    step(3);
    checks++; if (a_n !== 3'b000) begin failures++; $display("FAIL key76_a_n got=%b exp=000", a_n); end
    step(8);
    checks++; if (pulse_cnt - p0 !== 1) begin failures++; $display("FAIL key76_no_repulse got=%0d exp=1", pulse_cnt - p0); end
  endtask

  task automatic test_bounce();
    go_idle();
    p0 = pulse_cnt;
    for (int i = 0; i < 8; i++) begin
      key_n = (i % 2 == 0) ? 8'hFE : 8'hFF;
      step(1);
    end
    key_n = 8'hFE;
    step(5);
    checks++; if (pulse_cnt - p0 !== 0) begin failures++; $display("FAIL bounce_no_pulse got=%0d exp=0", pulse_cnt - p0); end
    step(1);
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL bounce_valid got=%b exp=1", key_valid); end
    checks++; if (key_code !== 3'd0) begin failures++; $display("FAIL bounce_code got=%0d exp=0", key_code); end
    step(5);
    checks++; if (pulse_cnt - p0 !== 1) begin failures++; $display("FAIL bounce_pulses got=%0d exp=1", pulse_cnt - p0); end
  endtask

  task automatic test_release_glitch();
    p0 = pulse_cnt;
    key_n = 8'hDF;
    step(10);
    checks++; if (pulse_cnt - p0 !== 1 || key_code !== 3'd5) begin failures++; $display("FAIL key5_press got=%0d/%0d exp=1/5", pulse_cnt - p0, key_code); end
    key_n = 8'hFF;
    step(2);
    key_n = 8'hDF;
    step(10);
    checks++; if (pulse_cnt - p0 !== 1) begin failures++; $display("FAIL glitch_no_pulse got=%0d exp=1", pulse_cnt - p0); end
    key_n = 8'hFF;
    step(4);
    key_n = 8'hDF;
    step(10);
    checks++; if (pulse_cnt - p0 !== 2) begin failures++; $display("FAIL release4_repulse got=%0d exp=2", pulse_cnt - p0); end
    checks++; if (key_code !== 3'd5) begin failures++; $display("FAIL release4_code got=%0d exp=5", key_code); end
  endtask

  task automatic test_disable();
    key_n = 8'hF7;
    step(10);
    checks++; if (a_n !== 3'b100 || key_code !== 3'd3) begin failures++; $display("FAIL key3_held got=%b/%0d exp=100/3", a_n, key_code); end
    p0 = pulse_cnt;
    ei_n = 1'b1;
    step(2);
    checks++; if (a_n !== 3'b100) begin failures++; $display("FAIL dis_lat2_a_n got=%b exp=100", a_n); end
    step(1);
    checks++; if ({a_n, gs_n, eo_n} !== 5'b11111) begin failures++; $display("FAIL dis_outputs got=%b exp=11111", {a_n, gs_n, eo_n}); end
    step(8);
    checks++; if (pulse_cnt - p0 !== 0) begin failures++; $display("FAIL dis_no_pulse got=%0d exp=0", pulse_cnt - p0); end
    ei_n = 1'b0;
    step(10);
    checks++; if (pulse_cnt - p0 !== 1 || key_code !== 3'd3) begin failures++; $display("FAIL reenable_pulse got=%0d/%0d exp=1/3", pulse_cnt - p0, key_code); end
  endtask

  task automatic test_reset_mid_settle();
    go_idle();
    p0 = pulse_cnt;
    key_n = 8'hEF;
    step(4);
    rst = 1'b1;
    #1;
    checks++; if ({a_n, gs_n, eo_n} !== 5'b11111) begin failures++; $display("FAIL async_rst_outputs got=%b exp=11111", {a_n, gs_n, eo_n}); end
    key_n = 8'hFF;
    step(2);
    rst = 1'b0;
    step(10);
    checks++; if (pulse_cnt - p0 !== 0) begin failures++; $display("FAIL rst_settle_no_pulse got=%0d exp=0", pulse_cnt - p0); end
    checks++; if (key_code !== 3'd0) begin failures++; $display("FAIL rst_settle_code got=%0d exp=0", key_code); end
    checks++; if (eo_n !== 1'b0) begin failures++; $display("FAIL rst_settle_eo_n got=%b exp=0", eo_n); end
  endtask

  initial begin
    test_reset();
    test_encode_key2();
    test_multi_key();
    test_bounce();
    test_release_glitch();
    test_disable();
    test_reset_mid_settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
